// File: rtl/window3x3_stream_if.sv
// Pixel stream in, 3x3 window stream out, for the window3x3_stream block.
// master = pixel producer / window consumer side; slave = the window generator.
// No backpressure: a pixel is taken whenever in_valid is high.
interface window3x3_stream_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  logic                  in_valid;
  logic                  in_sof;
  logic                  in_sol;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic [9*DATA_W-1:0]   out_window;
  logic [ADDR_W-1:0]     out_col;
  logic                  out_sof;

  modport master (
    output in_valid, in_sof, in_sol, in_data,
    input  out_valid, out_window, out_col, out_sof
  );

  modport slave (
    input  in_valid, in_sof, in_sol, in_data,
    output out_valid, out_window, out_col, out_sof
  );
endinterface

// File: rtl/window3x3_stream.sv
// 3x3 neighbourhood generator: two line memories plus a shifting column pair; border taps masked.
// Latency: one cycle from accepted pixel to registered window (w8 = current pixel, bottom-right).
// No backpressure: every in_valid pixel is consumed; outputs hold while in_valid is low.
module window3x3_stream #(
  parameter int DATA_W      = 8,
  parameter int LINE_W      = 1280,
  parameter int ADDR_W      = 11,
  parameter int BORDER_MODE = 0
) (
  input logic               clk,
  input logic               rst_n,
  window3x3_stream_if.slave bus
);

  logic [ADDR_W-1:0]   col, pos_col, nxt_col;
  logic [1:0]          row, pos_row, nxt_row;

  // Line memories: l1 holds line r-1, l2 holds line r-2, both indexed by column.
  logic [DATA_W-1:0]   l1_mem [LINE_W];
  logic [DATA_W-1:0]   l2_mem [LINE_W];
  logic [DATA_W-1:0]   l1_rd, l2_rd;

  // Raw column registers: mid = column c-1, lft = column c-2 (top/middle/bottom).
  logic [DATA_W-1:0]   mid_t, mid_m, mid_b;
  logic [DATA_W-1:0]   lft_t, lft_m, lft_b;

  logic [2:0]          row_ok, col_ok;   // index 0 = top row / left column
  logic [DATA_W-1:0]   raw  [3][3];
  logic [DATA_W-1:0]   rrep [3][3];
  logic [DATA_W-1:0]   tap  [3][3];
  logic [9*DATA_W-1:0] win_nxt;

  logic                out_valid_q, out_sof_q;
  logic [9*DATA_W-1:0] out_window_q;
  logic [ADDR_W-1:0]   out_col_q;

  // Position of the incoming pixel after frame/line sync, and the position that follows it.
  always_comb begin
    pos_col = col;
    pos_row = row;
    if (bus.in_sof) begin
      pos_col = '0;
      pos_row = '0;
    end else if (bus.in_sol && col != '0) begin
      pos_col = '0;
      pos_row = (row == 2'd2) ? 2'd2 : row + 2'd1;
    end
    nxt_col = pos_col + 1'b1;
    nxt_row = pos_row;
    if (pos_col == ADDR_W'(LINE_W - 1)) begin
      nxt_col = '0;
      nxt_row = (pos_row == 2'd2) ? 2'd2 : pos_row + 2'd1;
    end
  end

  assign l1_rd = l1_mem[pos_col];
  assign l2_rd = l2_mem[pos_col];

  // Assemble the raw 3x3 taps and substitute invalid border taps.
  always_comb begin
    row_ok = {1'b1, pos_row != 2'd0, pos_row == 2'd2};
    col_ok = {1'b1, pos_col != '0, pos_col > ADDR_W'(1)};
    raw[0][0] = lft_t;  raw[0][1] = mid_t;  raw[0][2] = l2_rd;
    raw[1][0] = lft_m;  raw[1][1] = mid_m;  raw[1][2] = l1_rd;
    raw[2][0] = lft_b;  raw[2][1] = mid_b;  raw[2][2] = bus.in_data;
    rrep    = raw;
    tap     = raw;
    win_nxt = '0;
    if (BORDER_MODE == 0) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          tap[i][j] = (row_ok[i] && col_ok[j]) ? raw[i][j] : '0;
    end else begin
      // Rows first: an invalid row takes the nearest valid row below it.
      for (int j = 0; j < 3; j++) begin
        rrep[1][j] = row_ok[1] ? raw[1][j] : raw[2][j];
        rrep[0][j] = row_ok[0] ? raw[0][j] : rrep[1][j];
      end
      // Then columns: an invalid column takes the nearest valid column to its right.
      for (int i = 0; i < 3; i++) begin
        tap[i][2] = rrep[i][2];
        tap[i][1] = col_ok[1] ? rrep[i][1] : tap[i][2];
        tap[i][0] = col_ok[0] ? rrep[i][0] : tap[i][1];
      end
    end
    for (int k = 0; k < 9; k++)
      win_nxt[k*DATA_W +: DATA_W] = tap[k/3][k%3];
  end

  // Counters, column shift registers and output registers advance only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      mid_t        <= '0;
      mid_m        <= '0;
      mid_b        <= '0;
      lft_t        <= '0;
      lft_m        <= '0;
      lft_b        <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_window_q <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        col          <= nxt_col;
        row          <= nxt_row;
        lft_t        <= mid_t;
        lft_m        <= mid_m;
        lft_b        <= mid_b;
        mid_t        <= l2_rd;
        mid_m        <= l1_rd;
        mid_b        <= bus.in_data;
        out_sof_q    <= bus.in_sof;
        out_window_q <= win_nxt;
        out_col_q    <= pos_col;
      end
    end
  end

  // Line memory update: read-before-write, the old l1 entry moves down into l2.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      l2_mem[pos_col] <= l1_rd;
      l1_mem[pos_col] <= bus.in_data;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.out_window = out_window_q;
  assign bus.out_col    = out_col_q;

endmodule

// File: tb/tb_window3x3_stream.sv
// Drives one pixel stream into a zero-border and a replicate-border instance (LINE_W=4)
// and compares every cycle against a per-column pixel-history reference model.
module tb_window3x3_stream;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic in_sol = 1'b0;
  logic [DW-1:0] in_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  window3x3_stream_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  window3x3_stream_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_sof   = in_sof;
  assign bus0.in_sol   = in_sol;
  assign bus0.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign bus1.in_sof   = in_sof;
  assign bus1.in_sol   = in_sol;
  assign bus1.in_data  = in_data;

  window3x3_stream #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW), .BORDER_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  window3x3_stream #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW), .BORDER_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // Reference model: frame position plus, per column, the last three pixels written there.
  int m_row = 0;
  int m_col = 0;
  logic [DW-1:0] hist [LW][3];
  logic [9*DW-1:0] e_win0 = '0;
  logic [9*DW-1:0] e_win1 = '0;
  logic [AW-1:0]   e_col = '0;
  logic            e_sof = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    int a [9];
    logic [9*DW-1:0] w;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(a[k]);
    return w;
  endfunction

  function automatic bit row_valid(input int i, input int r);
    return (i == 2) || (i == 1 && r >= 1) || (i == 0 && r >= 2);
  endfunction

  function automatic bit col_valid(input int j, input int c);
    return (j == 2) || (j == 1 && c >= 1) || (j == 0 && c >= 2);
  endfunction

  task automatic model_step(input bit sof, input bit sol, input logic [DW-1:0] d);
    int r, c, cc, ri, cj;
    logic [DW-1:0] raw [3][3];
    if (sof) begin
      r = 0; c = 0;
    end else if (sol && m_col != 0) begin
      r = (m_row >= 2) ? 2 : m_row + 1; c = 0;
    end else begin
      r = m_row; c = m_col;
    end
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) raw[i][j] = '0;
      if (col_valid(j, c)) begin
        if (j == 2) begin
          raw[2][2] = d; raw[1][2] = hist[c][0]; raw[0][2] = hist[c][1];
        end else begin
          cc = c - (2 - j);
          raw[2][j] = hist[cc][0]; raw[1][j] = hist[cc][1]; raw[0][j] = hist[cc][2];
        end
      end
    end
    e_win0 = '0;
    e_win1 = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (row_valid(i, r) && col_valid(j, c)) e_win0[(i*3+j)*DW +: DW] = raw[i][j];
        ri = i;
        while (!row_valid(ri, r)) ri++;
        cj = j;
        while (!col_valid(cj, c)) cj++;
        e_win1[(i*3+j)*DW +: DW] = raw[ri][cj];
      end
    end
    e_col = AW'(c);
    e_sof = sof;
    hist[c][2] = hist[c][1];
    hist[c][1] = hist[c][0];
    hist[c][0] = d;
    if (c == LW - 1) begin
      m_col = 0; m_row = (r >= 2) ? 2 : r + 1;
    end else begin
      m_col = c + 1; m_row = r;
    end
  endtask

  task automatic check_outputs(input bit v);
    check("out_valid0", bus0.out_valid, v);
    check("out_valid1", bus1.out_valid, v);
    check("window0", bus0.out_window, e_win0);
    check("window1", bus1.out_window, e_win1);
    check("out_col0", bus0.out_col, e_col);
    check("out_col1", bus1.out_col, e_col);
    check("out_sof0", bus0.out_sof, e_sof);
    check("out_sof1", bus1.out_sof, e_sof);
  endtask

  task automatic drive(input bit v, input bit sof, input bit sol, input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = v; in_sof = sof; in_sol = sol; in_data = d;
    if (v) model_step(sof, sol, d);
    @(posedge clk);
    #1;
    check_outputs(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_row = 0; m_col = 0;
    e_win0 = '0; e_win1 = '0; e_col = '0; e_sof = 1'b0;
    check_outputs(1'b0);
    drive(0, 0, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < LW; c++)
      for (int k = 0; k < 3; k++) hist[c][k] = '0;

    // Reset then idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) drive(0, 0, 0, '0);

    // Frame 0..15, continuous valid.
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0, 0, DW'(i));
      if (i == 4) check("dir_pix4_m0", bus0.out_window, pack9(0, 0, 0, 0, 0, 0, 0, 0, 4));
      if (i == 5) check("dir_pix5_m1", bus1.out_window, pack9(0, 0, 1, 0, 0, 1, 4, 4, 5));
      if (i == 10) begin
        check("dir_pix10_m0", bus0.out_window, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check("dir_pix10_m1", bus1.out_window, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      end
    end
    repeat (2) drive(0, 0, 0, '0);

    // Same frame with in_valid toggling every cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0, 0, DW'(i));
      if (i == 10) check("tog_pix10_m0", bus0.out_window, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      drive(0, 0, 0, DW'(i));
    end

    // Mid-frame in_sof at pixel 9.
    for (int i = 0; i < 16; i++) begin
      drive(1, (i == 0) || (i == 9), 0, DW'(i + 100));
      if (i == 9) begin
        check("sof9_m0", bus0.out_window, pack9(0, 0, 0, 0, 0, 0, 0, 0, 109));
        check("sof9_m1", bus1.out_window, pack9(109, 109, 109, 109, 109, 109, 109, 109, 109));
        check("sof9_flag", bus0.out_sof, 1'b1);
        check("sof9_col", bus0.out_col, 0);
      end
    end

    // in_sol at column 2 starts a new line.
    drive(1, 1, 0, 8'd20);
    drive(1, 0, 0, 8'd21);
    drive(1, 0, 1, 8'd22);
    check("sol_col", bus0.out_col, 0);
    check("sol_win", bus0.out_window, pack9(0, 0, 0, 0, 0, 20, 0, 0, 22));
    drive(1, 0, 0, 8'd23);
    check("sol_next", bus0.out_window, pack9(0, 0, 0, 0, 20, 21, 0, 22, 23));

    // Random traffic with a mid-line reset.
    for (int it = 0; it < 600; it++) begin
      if (it == 300) begin
        do_reset();
        drive(1, 0, 0, 8'd55);
        check("rst_first_col", bus0.out_col, 0);
        check("rst_first_win", bus0.out_window, pack9(0, 0, 0, 0, 0, 0, 0, 0, 55));
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 5) == 0, DW'($urandom));
      end
    end
    drive(0, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
